sgpr_busy_table: RTL and testbench

Scoreboard of scalar GPR busy bits for the issue stage.
- Issue side: marks destination SGPRs busy when an instruction issues.
- Write-back side: clears them on retire.
- Dependency check: answers, with one-cycle latency, whether up to two source operands are still busy.
- Consumes (addr, word-mask) pairs and expands them internally into per-register bits, wrapping past the top register.

---
 rtl/sgpr_busy_table.sv | 141 ++++++++++++++
 tb/tb_sgpr_busy_table.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgpr_busy_table.sv
`default_nettype none
// ============================================================================
// Module   : sgpr_busy_table
// Purpose  : Scalar GPR busy-bit scoreboard for the issue stage. Issue marks
//            destination registers busy; write-back releases them; a
//            dependency query reports (one cycle later) whether any register
//            covered by up to two source operands is still busy.
//            Operands arrive as (base address, word mask) pairs and are
//            expanded to per-register bits, wrapping past the top register.
// Ports    : clk, rst_n (async active-low)
//            set_en/set_addr/set_mask   - issue-side busy marking
//            clr_en/clr_addr/clr_mask   - write-back release
//            chk_en/chk_addr0/chk_mask0/chk_addr1/chk_mask1 - query
//            chk_rsp_valid/chk_busy     - query response (1-cycle latency)
//            busy_count/all_idle        - registered occupancy status
//            err_double_set/err_clr_idle - sticky protocol error flags,
//                                          present only when the macro
//                                          SGPR_BUSY_TABLE_ERR_CHECK_EN
//                                          is defined
// Revision : 1.0 - initial release
// ============================================================================
module sgpr_busy_table #(
    parameter int NUMBER_SGPR = 512,
    parameter int SGPR_ADDR_W = 9,
    parameter int MAX_WORDS   = 4,
    parameter int COUNT_W     = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_en,
    input  logic [SGPR_ADDR_W-1:0] set_addr,
    input  logic [MAX_WORDS-1:0]   set_mask,
    input  logic                   clr_en,
    input  logic [SGPR_ADDR_W-1:0] clr_addr,
    input  logic [MAX_WORDS-1:0]   clr_mask,
    input  logic                   chk_en,
    input  logic [SGPR_ADDR_W-1:0] chk_addr0,
    input  logic [MAX_WORDS-1:0]   chk_mask0,
    input  logic [SGPR_ADDR_W-1:0] chk_addr1,
    input  logic [MAX_WORDS-1:0]   chk_mask1,
    output logic                   chk_rsp_valid,
    output logic                   chk_busy,
    output logic [COUNT_W-1:0]     busy_count,
    output logic                   all_idle
`ifdef SGPR_BUSY_TABLE_ERR_CHECK_EN
    ,
    output logic                   err_double_set,
    output logic                   err_clr_idle
`endif
);

    // Expand (base, mask) to a one-hot-per-register vector. The index is
    // computed in SGPR_ADDR_W bits, so it wraps modulo NUMBER_SGPR for free.
    function automatic logic [NUMBER_SGPR-1:0] expand(
        input logic [SGPR_ADDR_W-1:0] addr,
        input logic [MAX_WORDS-1:0]   mask
    );
        logic [NUMBER_SGPR-1:0] bits;
        logic [SGPR_ADDR_W-1:0] idx;
        bits = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            idx = addr + SGPR_ADDR_W'(i);
            if (mask[i]) begin
                bits[idx] = 1'b1;
            end
        end
        return bits;
    endfunction

    logic [NUMBER_SGPR-1:0] r_table;
    logic [NUMBER_SGPR-1:0] w_set_bits;
    logic [NUMBER_SGPR-1:0] w_clr_bits;
    logic [NUMBER_SGPR-1:0] w_chk_bits;
    logic [NUMBER_SGPR-1:0] w_table_next;
    logic [COUNT_W-1:0]     w_next_count;
    logic                   w_chk_hit;

    always_comb begin
        w_set_bits = set_en ? expand(set_addr, set_mask) : '0;
        w_clr_bits = clr_en ? expand(clr_addr, clr_mask) : '0;
        w_chk_bits = expand(chk_addr0, chk_mask0) | expand(chk_addr1, chk_mask1);
        // Set wins over clear: the clear belongs to the previous writer,
        // while the new issue now owns the register.
        w_table_next = (r_table & ~w_clr_bits) | w_set_bits;
        // Queries look at the post-update table so same-cycle traffic counts.
        w_chk_hit = |(w_table_next & w_chk_bits);
    end

    // Popcount of the next table, so the registered count lines up with the
    // table register on the same edge.
    always_comb begin
        w_next_count = '0;
        for (int i = 0; i < NUMBER_SGPR; i++) begin
            w_next_count = w_next_count + COUNT_W'(w_table_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_table       <= '0;
            chk_rsp_valid <= 1'b0;
            chk_busy      <= 1'b0;
            busy_count    <= '0;
            all_idle      <= 1'b1;
        end else begin
            r_table       <= w_table_next;
            chk_rsp_valid <= chk_en;
            busy_count    <= w_next_count;
            all_idle      <= (w_next_count == '0);
            // chk_busy holds between responses.
            if (chk_en) begin
                chk_busy <= w_chk_hit;
            end
        end
    end

`ifdef SGPR_BUSY_TABLE_ERR_CHECK_EN
    logic w_double_set;
    logic w_clr_idle;

    always_comb begin
        // A set onto a busy register is legal only if that register is
        // released in the same cycle; symmetrically a clear of an idle
        // register is legal only if it is being set in the same cycle.
        w_double_set = |(w_set_bits & r_table & ~w_clr_bits);
        w_clr_idle   = |(w_clr_bits & ~r_table & ~w_set_bits);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_double_set <= 1'b0;
            err_clr_idle   <= 1'b0;
        end else begin
            err_double_set <= err_double_set | w_double_set;
            err_clr_idle   <= err_clr_idle | w_clr_idle;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sgpr_busy_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_sgpr_busy_table
// Purpose  : Directed self-checking bench for sgpr_busy_table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sgpr_busy_table;

    localparam int NUMBER_SGPR = 512;
    localparam int SGPR_ADDR_W = 9;
    localparam int MAX_WORDS   = 4;
    localparam int COUNT_W     = 10;

    logic                   clk;
    logic                   rst_n;
    logic                   set_en;
    logic [SGPR_ADDR_W-1:0] set_addr;
    logic [MAX_WORDS-1:0]   set_mask;
    logic                   clr_en;
    logic [SGPR_ADDR_W-1:0] clr_addr;
    logic [MAX_WORDS-1:0]   clr_mask;
    logic                   chk_en;
    logic [SGPR_ADDR_W-1:0] chk_addr0;
    logic [MAX_WORDS-1:0]   chk_mask0;
    logic [SGPR_ADDR_W-1:0] chk_addr1;
    logic [MAX_WORDS-1:0]   chk_mask1;
    logic                   chk_rsp_valid;
    logic                   chk_busy;
    logic [COUNT_W-1:0]     busy_count;
    logic                   all_idle;
`ifdef SGPR_BUSY_TABLE_ERR_CHECK_EN
    logic                   err_double_set;
    logic                   err_clr_idle;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    sgpr_busy_table #(
        .NUMBER_SGPR (NUMBER_SGPR),
        .SGPR_ADDR_W (SGPR_ADDR_W),
        .MAX_WORDS   (MAX_WORDS),
        .COUNT_W     (COUNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .set_en        (set_en),
        .set_addr      (set_addr),
        .set_mask      (set_mask),
        .clr_en        (clr_en),
        .clr_addr      (clr_addr),
        .clr_mask      (clr_mask),
        .chk_en        (chk_en),
        .chk_addr0     (chk_addr0),
        .chk_mask0     (chk_mask0),
        .chk_addr1     (chk_addr1),
        .chk_mask1     (chk_mask1),
        .chk_rsp_valid (chk_rsp_valid),
        .chk_busy      (chk_busy),
        .busy_count    (busy_count),
        .all_idle      (all_idle)
`ifdef SGPR_BUSY_TABLE_ERR_CHECK_EN
        ,
        .err_double_set(err_double_set),
        .err_clr_idle  (err_clr_idle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        set_en = 1'b0; set_addr = '0; set_mask = '0;
        clr_en = 1'b0; clr_addr = '0; clr_mask = '0;
        chk_en = 1'b0; chk_addr0 = '0; chk_mask0 = '0;
        chk_addr1 = '0; chk_mask1 = '0;
    endtask

    task automatic do_set(input int a, input logic [MAX_WORDS-1:0] m);
        idle_inputs();
        set_en = 1'b1; set_addr = SGPR_ADDR_W'(a); set_mask = m;
        tick();
        idle_inputs();
    endtask

    task automatic do_query(input int a0, input logic [MAX_WORDS-1:0] m0,
                            input int a1, input logic [MAX_WORDS-1:0] m1);
        idle_inputs();
        chk_en = 1'b1;
        chk_addr0 = SGPR_ADDR_W'(a0); chk_mask0 = m0;
        chk_addr1 = SGPR_ADDR_W'(a1); chk_mask1 = m1;
        tick();
        idle_inputs();
    endtask

    task automatic check_count(input string name, input int exp_cnt);
        total_cnt++;
        if (busy_count !== COUNT_W'(exp_cnt) || all_idle !== (exp_cnt == 0)) begin
            $display("FAIL %s: busy_count=%0d all_idle=%b, expected %0d/%b",
                     name, busy_count, all_idle, exp_cnt, (exp_cnt == 0));
        end else pass_cnt++;
    endtask

    task automatic check_rsp(input string name, input logic exp_busy);
        total_cnt++;
        if (chk_rsp_valid !== 1'b1 || chk_busy !== exp_busy) begin
            $display("FAIL %s: valid=%b busy=%b, expected 1/%b",
                     name, chk_rsp_valid, chk_busy, exp_busy);
        end else pass_cnt++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        total_cnt++;
        if (chk_rsp_valid !== 1'b0 || chk_busy !== 1'b0 ||
            busy_count !== '0 || all_idle !== 1'b1) begin
            $display("FAIL reset: valid=%b busy=%b count=%0d idle=%b, expected 0/0/0/1",
                     chk_rsp_valid, chk_busy, busy_count, all_idle);
        end else pass_cnt++;
`ifdef SGPR_BUSY_TABLE_ERR_CHECK_EN
        total_cnt++;
        if (err_double_set !== 1'b0 || err_clr_idle !== 1'b0) begin
            $display("FAIL reset_err: dbl=%b clr=%b, expected 0/0",
                     err_double_set, err_clr_idle);
        end else pass_cnt++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_set_basic();
        do_set(8, 4'b0011);
        check_count("set_8_9", 2);
        do_query(9, 4'b0001, 0, 4'b0000);
        check_rsp("query_9", 1'b1);
        tick();
        total_cnt++;
        if (chk_rsp_valid !== 1'b0 || chk_busy !== 1'b1) begin
            $display("FAIL rsp_hold: valid=%b busy=%b, expected 0/1",
                     chk_rsp_valid, chk_busy);
        end else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_set(510, 4'b1111);
        check_count("wrap_set", 6);
        do_query(0, 4'b0001, 0, 4'b0000);
        check_rsp("wrap_q0", 1'b1);
        do_query(2, 4'b0001, 0, 4'b0000);
        check_rsp("wrap_q2", 1'b0);
        do_query(8, 4'b0000, 510, 4'b0000);
        check_rsp("both_mask0", 1'b0);
        // en low ignores the mask; mask 0 with en high is a no-op
        idle_inputs();
        set_addr = 9'd200; set_mask = 4'b1111;
        tick();
        check_count("en_low_noop", 6);
        do_set(200, 4'b0000);
        check_count("mask0_noop", 6);
    endtask

    task automatic test_same_cycle_set_clr();
        do_set(20, 4'b0001);
        check_count("set_20", 7);
        idle_inputs();
        set_en = 1'b1; set_addr = 9'd20; set_mask = 4'b0001;
        clr_en = 1'b1; clr_addr = 9'd20; clr_mask = 4'b0001;
        chk_en = 1'b1; chk_addr0 = 9'd20; chk_mask0 = 4'b0001;
        tick();
        idle_inputs();
        check_count("setclr_20", 7);
        check_rsp("setclr_q20", 1'b1);
    endtask

    task automatic test_clear_query();
        do_set(40, 4'b0001);
        check_count("set_40", 8);
        idle_inputs();
        clr_en = 1'b1; clr_addr = 9'd40; clr_mask = 4'b0001;
        chk_en = 1'b1; chk_addr0 = 9'd40; chk_mask0 = 4'b0001;
        tick();
        idle_inputs();
        check_count("clr_40", 7);
        check_rsp("clr_q40", 1'b0);
    endtask

    task automatic test_overlap();
        // clear 8,9 and set 9,10 -> 8 idle, 9 busy (set wins), 10 busy
        idle_inputs();
        clr_en = 1'b1; clr_addr = 9'd8; clr_mask = 4'b0011;
        set_en = 1'b1; set_addr = 9'd9; set_mask = 4'b0011;
        chk_en = 1'b1;
        chk_addr0 = 9'd8;  chk_mask0 = 4'b0001;
        chk_addr1 = 9'd10; chk_mask1 = 4'b0001;
        tick();
        idle_inputs();
        check_count("overlap", 7);
        check_rsp("overlap_q8_10", 1'b1);
        do_query(8, 4'b0001, 0, 4'b0000);
        check_rsp("overlap_q8", 1'b0);
        do_query(0, 4'b0000, 9, 4'b0001);
        check_rsp("overlap_q9", 1'b1);
`ifdef SGPR_BUSY_TABLE_ERR_CHECK_EN
        total_cnt++;
        if (err_double_set !== 1'b0 || err_clr_idle !== 1'b0) begin
            $display("FAIL no_err_yet: dbl=%b clr=%b, expected 0/0",
                     err_double_set, err_clr_idle);
        end else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        do_set(100, 4'b1111);
        check_count("set_100", 11);
        idle_inputs();
        chk_en = 1'b1; chk_addr0 = 9'd100; chk_mask0 = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (chk_rsp_valid !== 1'b0 || chk_busy !== 1'b0 ||
            busy_count !== '0 || all_idle !== 1'b1) begin
            $display("FAIL mid_reset: valid=%b busy=%b count=%0d idle=%b, expected 0/0/0/1",
                     chk_rsp_valid, chk_busy, busy_count, all_idle);
        end else pass_cnt++;
        tick();
        rst_n = 1'b1;
        idle_inputs();
        tick();
        total_cnt++;
        if (chk_rsp_valid !== 1'b0 || busy_count !== '0 || all_idle !== 1'b1) begin
            $display("FAIL post_reset: valid=%b count=%0d idle=%b, expected 0/0/1",
                     chk_rsp_valid, busy_count, all_idle);
        end else pass_cnt++;
        do_query(100, 4'b1111, 0, 4'b0000);
        check_rsp("post_reset_q100", 1'b0);
    endtask

    task automatic test_err_stimulus();
        do_set(5, 4'b0001);
        check_count("err_set5", 1);
        do_set(5, 4'b0001);
        check_count("err_set5_again", 1);
`ifdef SGPR_BUSY_TABLE_ERR_CHECK_EN
        total_cnt++;
        if (err_double_set !== 1'b1 || err_clr_idle !== 1'b0) begin
            $display("FAIL err_double: dbl=%b clr=%b, expected 1/0",
                     err_double_set, err_clr_idle);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (err_double_set !== 1'b1) begin
            $display("FAIL err_double_sticky: dbl=%b, expected 1", err_double_set);
        end else pass_cnt++;
`endif
        idle_inputs();
        clr_en = 1'b1; clr_addr = 9'd300; clr_mask = 4'b0001;
        tick();
        idle_inputs();
        check_count("err_clr300", 1);
`ifdef SGPR_BUSY_TABLE_ERR_CHECK_EN
        total_cnt++;
        if (err_clr_idle !== 1'b1 || err_double_set !== 1'b1) begin
            $display("FAIL err_clr_idle: dbl=%b clr=%b, expected 1/1",
                     err_double_set, err_clr_idle);
        end else pass_cnt++;
`endif
        do_query(5, 4'b0001, 0, 4'b0000);
        check_rsp("err_q5", 1'b1);
        do_query(300, 4'b0001, 0, 4'b0000);
        check_rsp("err_q300", 1'b0);
    endtask

    initial begin
        test_reset();
        test_set_basic();
        test_wrap();
        test_same_cycle_set_clr();
        test_clear_query();
        test_overlap();
        test_reset_mid();
        test_err_stimulus();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
